// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: FSM state and access-size encodings.
// Size encodings are only used when MEM_SUBWORD_EN is defined.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_load_align.sv
// Load lane extraction: selects the byte/half addressed by addr_lo_i and
// sign- or zero-extends it. Instantiated by mem_wb_stage under MEM_SUBWORD_EN.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rdata_i,
  input  logic [1:0]    addr_lo_i,
  input  logic [1:0]    size_i,
  input  logic          unsigned_i,
  output logic [DW-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Halves ignore addr[0]: misaligned halves truncate to the aligned lane.
  assign byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_lane = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o = rdata_i;
    case (size_i)
      SZ_BYTE: data_o = unsigned_i ? {{(DW-8){1'b0}}, byte_lane}
                                   : {{(DW-8){byte_lane[7]}}, byte_lane};
      SZ_HALF: data_o = unsigned_i ? {{(DW-16){1'b0}}, half_lane}
                                   : {{(DW-16){half_lane[15]}}, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS MEM stage: data-memory valid/ack access, upstream stall, MEM/WB latch.
// Define MEM_SUBWORD_EN to honour size_i/unsigned_i (byte/half accesses).
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic [DW-1:0] alu_result_i,
  input  logic [DW-1:0] rt_data_i,
  input  logic          memread_i,
  input  logic          memwrite_i,
  input  logic          memtoreg_i,
  input  logic          regwrite_i,
  input  logic [RW-1:0] write_reg_i,
  input  logic [1:0]    size_i,
  input  logic          unsigned_i,
  output logic          stall_o,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [DW-1:0] dmem_addr_o,
  output logic [DW-1:0] dmem_wdata_o,
  output logic [3:0]    dmem_be_o,
  input  logic          dmem_ack_i,
  input  logic [DW-1:0] dmem_rdata_i,
  output logic          valid_o,
  output logic          memtoreg_o,
  output logic          regwrite_o,
  output logic [DW-1:0] alu_result_o,
  output logic [DW-1:0] data_mem_o,
  output logic [RW-1:0] write_reg_o
);

  state_e state_q, state_d;

  // Request latch, captured when a memory op is accepted in IDLE.
  logic [DW-1:0] addr_q, wdata_q;
  logic [3:0]    be_q;
  logic          we_q, rd_q, mtr_l_q, rw_l_q;
  logic [RW-1:0] wr_l_q;

  // MEM/WB latch.
  logic          valid_q, mtr_q, rw_q;
  logic          valid_d, mtr_d, rw_d;
  logic [DW-1:0] alu_q, dmem_q, alu_d, dmem_d;
  logic [RW-1:0] wr_q, wr_d;

  logic          is_mem, accept, done;
  logic [3:0]    st_be;
  logic [DW-1:0] st_wdata, load_data;

  assign is_mem = valid_i & (memread_i | memwrite_i);
  assign accept = (state_q == IDLE) & is_mem;
  assign done   = (state_q == BUSY) & dmem_ack_i;

`ifdef MEM_SUBWORD_EN
  logic [1:0] size_q;
  logic       uns_q;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = rt_data_i;
    case (size_i)
      SZ_BYTE: begin
        st_be    = 4'b0001 << alu_result_i[1:0];
        st_wdata = {4{rt_data_i[7:0]}};
      end
      SZ_HALF: begin
        st_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{rt_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      size_q <= SZ_WORD;
      uns_q  <= 1'b0;
    end else if (accept) begin
      size_q <= size_i;
      uns_q  <= unsigned_i;
    end
  end

  mem_load_align #(.DW(DW)) u_load_align (
    .rdata_i    (dmem_rdata_i),
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );
`else
  logic unused_subword;

  assign unused_subword = ^{size_i, unsigned_i};
  assign st_be          = 4'b1111;
  assign st_wdata       = rt_data_i;
  assign load_data      = dmem_rdata_i;
`endif

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_mem) state_d = BUSY;
      BUSY:    if (dmem_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Gated by rst_i so the stall drops the instant reset asserts.
  assign stall_o = rst_i & ((state_q == IDLE && is_mem) ||
                            (state_q == BUSY && !dmem_ack_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      mtr_l_q <= 1'b0;
      rw_l_q  <= 1'b0;
      wr_l_q  <= '0;
    end else if (accept) begin
      addr_q  <= alu_result_i;
      wdata_q <= st_wdata;
      be_q    <= st_be;
      we_q    <= memwrite_i;
      rd_q    <= memread_i & ~memwrite_i;
      mtr_l_q <= memtoreg_i;
      rw_l_q  <= regwrite_i;
      wr_l_q  <= write_reg_i;
    end
  end

  assign dmem_req_o   = (state_q == BUSY);
  assign dmem_we_o    = (state_q == BUSY) & we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;

  always_comb begin
    valid_d = 1'b0;
    mtr_d   = 1'b0;
    rw_d    = 1'b0;
    alu_d   = alu_q;
    dmem_d  = dmem_q;
    wr_d    = wr_q;
    if (done) begin
      valid_d = 1'b1;
      mtr_d   = mtr_l_q;
      rw_d    = rw_l_q;
      alu_d   = addr_q;
      dmem_d  = rd_q ? load_data : '0;
      wr_d    = wr_l_q;
    end else if (state_q == IDLE && valid_i && !is_mem) begin
      valid_d = 1'b1;
      mtr_d   = memtoreg_i;
      rw_d    = regwrite_i;
      alu_d   = alu_result_i;
      dmem_d  = '0;
      wr_d    = write_reg_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      mtr_q   <= 1'b0;
      rw_q    <= 1'b0;
      alu_q   <= '0;
      dmem_q  <= '0;
      wr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      mtr_q   <= mtr_d;
      rw_q    <= rw_d;
      alu_q   <= alu_d;
      dmem_q  <= dmem_d;
      wr_q    <= wr_d;
    end
  end

  assign valid_o      = valid_q;
  assign memtoreg_o   = mtr_q;
  assign regwrite_o   = rw_q & valid_q;
  assign alu_result_o = alu_q;
  assign data_mem_o   = dmem_q;
  assign write_reg_o  = wr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: transaction-level model plus directed
// literal checks. Subword cases run only when MEM_SUBWORD_EN is defined.
module tb_mem_wb_stage;
  import mem_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] alu_result_i = '0;
  logic [DW-1:0] rt_data_i = '0;
  logic          memread_i = 1'b0, memwrite_i = 1'b0;
  logic          memtoreg_i = 1'b0, regwrite_i = 1'b0;
  logic [RW-1:0] write_reg_i = '0;
  logic [1:0]    size_i = SZ_WORD;
  logic          unsigned_i = 1'b0;
  logic          stall_o, dmem_req_o, dmem_we_o;
  logic [DW-1:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]    dmem_be_o;
  logic          dmem_ack_i = 1'b0;
  logic [DW-1:0] dmem_rdata_i = '0;
  logic          valid_o, memtoreg_o, regwrite_o;
  logic [DW-1:0] alu_result_o, data_mem_o;
  logic [RW-1:0] write_reg_o;

  always #5 clk_i = ~clk_i;

  mem_wb_stage #(.DW(DW), .RW(RW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .alu_result_i (alu_result_i),
    .rt_data_i    (rt_data_i),
    .memread_i    (memread_i),
    .memwrite_i   (memwrite_i),
    .memtoreg_i   (memtoreg_i),
    .regwrite_i   (regwrite_i),
    .write_reg_i  (write_reg_i),
    .size_i       (size_i),
    .unsigned_i   (unsigned_i),
    .stall_o      (stall_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .valid_o      (valid_o),
    .memtoreg_o   (memtoreg_o),
    .regwrite_o   (regwrite_o),
    .alu_result_o (alu_result_o),
    .data_mem_o   (data_mem_o),
    .write_reg_o  (write_reg_o)
  );

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          cyc;
    logic [31:0] alu;
    logic [31:0] dmem;
    logic        mtr;
    logic        rw;
    logic [4:0]  wr;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en = 1'b0;

  // Optional literal store-side expectations for the next mem_op ack cycle.
  bit          lit_chk = 1'b0;
  logic [3:0]  lit_be  = '0;
  logic [31:0] lit_wd  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    v = rdata;
`ifdef MEM_SUBWORD_EN
    if (sz == SZ_BYTE) begin
      v = (rdata >> (8 * addr[1:0])) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == SZ_HALF) begin
      v = (rdata >> (16 * addr[1])) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
`endif
    return v;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz,
                             output logic [3:0] be, output logic [31:0] wd);
    be = 4'b1111;
    wd = data;
`ifdef MEM_SUBWORD_EN
    if (sz == SZ_BYTE) begin
      be = 4'b0001 << addr[1:0];
      wd = data[7:0] * 32'h0101_0101;
    end else if (sz == SZ_HALF) begin
      be = addr[1] ? 4'b1100 : 4'b0011;
      wd = data[15:0] * 32'h0001_0001;
    end
`endif
  endtask

  // Write-back compare: every valid MEM/WB beat must match the oldest expectation.
  always @(negedge clk_i) begin : wb_compare
    exp_t e;
    if (mon_en && rst_i) begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", valid_o, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("wb_cycle", cyc, e.cyc);
          check("wb_alu_result", alu_result_o, e.alu);
          check("wb_data_mem", data_mem_o, e.dmem);
          check("wb_memtoreg", memtoreg_o, e.mtr);
          check("wb_regwrite", regwrite_o, e.rw);
          check("wb_write_reg", write_reg_o, e.wr);
        end
      end else begin
        check("regwrite_when_invalid", regwrite_o, 1'b0);
        if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
          e = exp_q.pop_front();
          check("wb_overdue", cyc, e.cyc);
        end
      end
    end
  end

  task automatic alu_op(input logic [31:0] res, input logic rw, input logic [4:0] wr, input logic mtr);
    exp_t x;
    valid_i = 1'b1; memread_i = 1'b0; memwrite_i = 1'b0;
    alu_result_i = res; rt_data_i = 32'h5555_AAAA;
    regwrite_i = rw; write_reg_i = wr; memtoreg_i = mtr;
    size_i = SZ_WORD; unsigned_i = 1'b0;
    x = '{cyc: cyc + 1, alu: res, dmem: 32'h0, mtr: mtr, rw: rw, wr: wr};
    exp_q.push_back(x);
    @(negedge clk_i);
    check("alu_stall", stall_o, 1'b0);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic mem_op(input logic [31:0] addr, input logic [31:0] wd, input logic rd, input logic wr_en,
                        input logic rw, input logic [4:0] wreg, input logic [1:0] sz, input logic uns,
                        input int nwait, input logic [31:0] rdata,
                        output int stall_cnt, output int lat);
    int          t0;
    exp_t        x;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    t0 = cyc;
    valid_i = 1'b1; memread_i = rd; memwrite_i = wr_en;
    alu_result_i = addr; rt_data_i = wd;
    regwrite_i = rw; write_reg_i = wreg; memtoreg_i = rd;
    size_i = sz; unsigned_i = uns;
    model_store(addr, wd, sz, ebe, ewd);
    x = '{cyc: t0 + nwait + 2, alu: addr,
          dmem: (rd && !wr_en) ? model_load(rdata, addr, sz, uns) : 32'h0,
          mtr: rd, rw: rw, wr: wreg};
    exp_q.push_back(x);
    stall_cnt = 0;
    @(negedge clk_i);
    check("accept_stall", stall_o, 1'b1);
    check("accept_req_low", dmem_req_o, 1'b0);
    if (stall_o) stall_cnt++;
    for (int i = 0; i <= nwait; i++) begin
      @(posedge clk_i); #1;
      alu_result_i = ~addr;
      rt_data_i    = ~wd;
      if (i == nwait) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdata;
      end else begin
        dmem_rdata_i = 32'h0BAD_0BAD;
      end
      @(negedge clk_i);
      check("busy_req", dmem_req_o, 1'b1);
      check("busy_we", dmem_we_o, wr_en);
      check("busy_addr", dmem_addr_o, addr);
      if (wr_en) begin
        check("busy_wdata", dmem_wdata_o, ewd);
        check("busy_be", dmem_be_o, ebe);
      end
      if (i == nwait && lit_chk) begin
        check("lit_be", dmem_be_o, lit_be);
        check("lit_wdata", dmem_wdata_o, lit_wd);
      end
      check("busy_stall", stall_o, (i == nwait) ? 1'b0 : 1'b1);
      if (stall_o) stall_cnt++;
    end
    @(posedge clk_i); #1;
    dmem_ack_i = 1'b0;
    valid_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0;
    lit_chk = 1'b0;
    lat = cyc - t0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int sc, lat;

    // Reset state.
    #3;
    check("rst_valid", valid_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_req", dmem_req_o, 1'b0);
    check("rst_be", dmem_be_o, 4'b0000);
    @(negedge clk_i);
    rst_i = 1'b1;
    mon_en = 1'b1;
    @(posedge clk_i); #1;

    // ALU op, single-cycle latency.
    alu_op(32'h0000_1234, 1'b1, 5'd8, 1'b0);
    check("alu_result_lit", alu_result_o, 32'h0000_1234);
    check("alu_regwrite_lit", regwrite_o, 1'b1);
    check("alu_write_reg_lit", write_reg_o, 5'd8);
    check("alu_data_mem_lit", data_mem_o, 32'h0);

    // Word load, ack after 3 BUSY cycles.
    mem_op(32'h0000_0100, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9, SZ_WORD, 1'b0, 3, 32'hDEAD_BEEF, sc, lat);
    check("lw_stall_cycles", sc, 4);
    check("lw_latency", lat, 5);
    check("lw_data_lit", data_mem_o, 32'hDEAD_BEEF);
    check("lw_memtoreg_lit", memtoreg_o, 1'b1);
    check("lw_valid_lit", valid_o, 1'b1);

    // Word store, ack on first BUSY cycle.
    lit_chk = 1'b1; lit_be = 4'b1111; lit_wd = 32'hCAFE_F00D;
    mem_op(32'h0000_0200, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 5'd0, SZ_WORD, 1'b0, 0, 32'h0, sc, lat);
    check("sw_latency", lat, 2);
    check("sw_regwrite_lit", regwrite_o, 1'b0);
    check("sw_data_mem_lit", data_mem_o, 32'h0);

    // Spurious ack while idle.
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'h1111_2222;
    @(negedge clk_i);
    check("spur_req", dmem_req_o, 1'b0);
    check("spur_stall", stall_o, 1'b0);
    @(posedge clk_i); #1;
    dmem_ack_i = 1'b0;
    check("spur_valid", valid_o, 1'b0);
    alu_op(32'h0000_ABCD, 1'b1, 5'd17, 1'b0);

    // Load with one wait, back-to-back ALU ops, store setting both read and write.
    mem_op(32'h0000_0340, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3, SZ_WORD, 1'b0, 1, 32'h0123_4567, sc, lat);
    check("lw1_latency", lat, 3);
    alu_op(32'hFFFF_FFFF, 1'b0, 5'd31, 1'b0);
    alu_op(32'h8000_0000, 1'b1, 5'd1, 1'b1);
    mem_op(32'h0000_0044, 32'h7777_8888, 1'b1, 1'b1, 1'b0, 5'd2, SZ_WORD, 1'b0, 2, 32'h9999_9999, sc, lat);
    check("rw_both_data_mem", data_mem_o, 32'h0);

`ifdef MEM_SUBWORD_EN
    mem_op(32'h0000_0103, 32'h0, 1'b1, 1'b0, 1'b1, 5'd4, SZ_BYTE, 1'b0, 1, 32'h8000_0000, sc, lat);
    check("lb_lit", data_mem_o, 32'hFFFF_FF80);
    mem_op(32'h0000_0103, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5, SZ_BYTE, 1'b1, 0, 32'h8000_0000, sc, lat);
    check("lbu_lit", data_mem_o, 32'h0000_0080);
    mem_op(32'h0000_0106, 32'h0, 1'b1, 1'b0, 1'b1, 5'd6, SZ_HALF, 1'b0, 0, 32'h9ABC_1234, sc, lat);
    check("lh_lit", data_mem_o, 32'hFFFF_9ABC);
    lit_chk = 1'b1; lit_be = 4'b1100; lit_wd = 32'h1234_1234;
    mem_op(32'h0000_0202, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 5'd0, SZ_HALF, 1'b0, 0, 32'h0, sc, lat);
    lit_chk = 1'b1; lit_be = 4'b0010; lit_wd = 32'h5A5A_5A5A;
    mem_op(32'h0000_0301, 32'h0000_005A, 1'b0, 1'b1, 1'b0, 5'd0, SZ_BYTE, 1'b0, 1, 32'h0, sc, lat);
`endif

    // Reset while BUSY: request and stall drop asynchronously.
    valid_i = 1'b1; memread_i = 1'b1; memwrite_i = 1'b0;
    alu_result_i = 32'h0000_0500; regwrite_i = 1'b1; write_reg_i = 5'd12; memtoreg_i = 1'b1;
    size_i = SZ_WORD;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("pre_rst_req", dmem_req_o, 1'b1);
    #2;
    rst_i = 1'b0;
    #1;
    check("rst_busy_req", dmem_req_o, 1'b0);
    check("rst_busy_stall", stall_o, 1'b0);
    check("rst_busy_valid", valid_o, 1'b0);
    @(negedge clk_i);
    valid_i = 1'b0; memread_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("post_rst_req", dmem_req_o, 1'b0);
    alu_op(32'h0000_0777, 1'b1, 5'd7, 1'b0);
    check("post_rst_alu_lit", alu_result_o, 32'h0000_0777);

    repeat (3) @(posedge clk_i);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage of the five-stage MIPS pipeline, sitting between the EX/MEM latch and the write-back mux. It issues loads and stores to the data memory over a valid/ack handshake, stalls the front of the pipeline while an access is outstanding, and registers the ALU result, load data and write-back controls into the MEM/WB latch that the write-back stage consumes.

## Interface
Parameters:
- DW, 32, data and address width
- RW, 5, register-index width

Ports:
- clk_i  in  1  pipeline clock
- rst_i  in  1  reset; one clock, reset is asynchronous and active-low
- valid_i  in  1  EX/MEM slot holds an instruction
- alu_result_i  in  DW  ALU result / effective address
- rt_data_i  in  DW  store data
- memread_i, memwrite_i, memtoreg_i, regwrite_i  in  1 each  controls from EX/MEM
- write_reg_i  in  RW  destination register
- size_i  in  2  00 byte, 01 half, 10 word (used only with MEM_SUBWORD_EN)
- unsigned_i  in  1  zero-extend loads (used only with MEM_SUBWORD_EN)
- stall_o  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- dmem_req_o, dmem_we_o  out  1 each  request, write enable
- dmem_addr_o, dmem_wdata_o  out  DW  address, store data
- dmem_be_o  out  4  byte enables
- dmem_ack_i  in  1  access complete; dmem_rdata_i valid this cycle
- dmem_rdata_i  in  DW  load data
- valid_o, memtoreg_o, regwrite_o  out  1 each  MEM/WB controls
- alu_result_o, data_mem_o  out  DW  to write-back mux inputs 0/1
- write_reg_o  out  RW  destination register

## Operation
- FSM states IDLE, BUSY.
- IDLE, valid_i=1, memread_i=memwrite_i=0: MEM/WB latch loads inputs at next edge; data_mem_o=0; stall_o=0.
- IDLE, valid_i=1, memread_i|memwrite_i: stall_o=1 combinationally; at the edge latch address, store data, byte enables, controls; go BUSY; MEM/WB latch gets valid_o=0 (bubble).
- BUSY: dmem_req_o=1 with latched fields held stable; dmem_we_o=memwrite; stall_o=1; inputs ignored.
- BUSY with dmem_ack_i=1: at that edge load MEM/WB from latched fields, data_mem_o=aligned dmem_rdata_i for loads, 0 for stores; go IDLE; stall_o=0 that same cycle, so upstream advances.
- dmem_ack_i in IDLE ignored. memread_i and memwrite_i both set: treated as store.
- regwrite_o forced 0 whenever valid_o=0.

## Timing
- Reset (async, rst_i=0): state IDLE; all outputs 0 (dmem_be_o=0, valid_o=0, stall_o=0).
- Reset during BUSY: request dropped immediately; memory must tolerate abandoned request.
- Non-memory op: 1-cycle latency to MEM/WB outputs.
- Memory op, ack N cycles after BUSY entry (N>=0): outputs valid at edge N+2 after acceptance; minimum 2 cycles.
- dmem_req_o stays high until the ack cycle inclusive; no back-to-back issue without an IDLE cycle.

## Configuration
- MEM_SUBWORD_EN defined: size_i/unsigned_i honoured. Stores: byte-enable selected by addr[1:0] (half uses addr[1]), data replicated across lanes. Loads: lane extracted, sign-extended unless unsigned_i. Misaligned half/word: low address bits ignored (truncated alignment).
- Undefined: every access word; dmem_be_o=4'b1111; data_mem_o=dmem_rdata_i; size_i/unsigned_i unused.

## Structure
- Package mem_pkg: state enum (IDLE, BUSY), size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
- One sub-module, mem_load_align: combinational lane extract and extend, instantiated only under MEM_SUBWORD_EN.

## Test plan
- Reset mid-BUSY (req high): rst_i=0 -> dmem_req_o=0, stall_o=0, valid_o=0 asynchronously; IDLE after release.
- ALU op alu_result_i=0x1234, regwrite_i=1, write_reg_i=8 -> next edge alu_result_o=0x1234, regwrite_o=1, write_reg_o=8, stall_o=0 throughout.
- Word load addr 0x100, ack after 3 BUSY cycles, rdata 0xDEADBEEF -> stall_o high 4 cycles, data_mem_o=0xDEADBEEF, memtoreg_o=1 at following edge.
- Store addr 0x200, data 0xCAFEF00D, ack same cycle as entering BUSY -> dmem_we_o=1, be=4'b1111, regwrite_o=0, 2-cycle latency.
- MEM_SUBWORD_EN: LB addr 0x103, rdata 0x80000000 -> data_mem_o=0xFFFFFF80; LBU -> 0x00000080; SH addr 0x202 data 0x1234 -> be=4'b1100, wdata=0x12341234.
- Spurious dmem_ack_i in IDLE -> no state or output change.
